// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised sign/exponent/mantissa adder.
package fp_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_ALIGN  = 3'd2,
      S_ADD    = 3'd3,
      S_NORM   = 3'd4,
      S_ROUND  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam int ST_EXACT     = 0;
   localparam int ST_OVERFLOW  = 1;
   localparam int ST_UNDERFLOW = 2;
   localparam int ST_INEXACT   = 3;

   localparam logic [3:0] STAT_EXACT     = 4'b0001 << ST_EXACT;
   localparam logic [3:0] STAT_OVERFLOW  = 4'b0001 << ST_OVERFLOW;
   localparam logic [3:0] STAT_UNDERFLOW = 4'b0001 << ST_UNDERFLOW;
   localparam logic [3:0] STAT_INEXACT   = 4'b0001 << ST_INEXACT;

   function automatic int bias(input int expW);
      return (1 << (expW - 1)) - 1;
   endfunction

   function automatic int exp_all_ones(input int expW);
      return (1 << expW) - 1;
   endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised mantissa, with renormalisation and overflow detection.
module fp_round_rne
   import fp_pkg::*;
#(
   parameter int EXP_W = 6,
   parameter int MAN_W = 25
) (
   input  logic [MAN_W:0]          mant_i,
   input  logic                    g_i,
   input  logic                    r_i,
   input  logic                    s_i,
   input  logic signed [EXP_W+1:0] exp_i,
   output logic [MAN_W-1:0]        man_o,
   output logic [EXP_W-1:0]        exp_o,
   output logic                    inexact_o,
   output logic                    overflow_o
);

   localparam logic signed [EXP_W+1:0] ONES_X = (EXP_W + 2)'(exp_all_ones(EXP_W));
   localparam logic signed [EXP_W+1:0] ONE_X  = (EXP_W + 2)'(1);

   logic                    roundUp;
   logic [MAN_W+1:0]        sum;
   logic signed [EXP_W+1:0] expAdj;

   always_comb begin
      roundUp = g_i & (r_i | s_i | mant_i[0]);
      sum     = {1'b0, mant_i} + {{(MAN_W + 1){1'b0}}, roundUp};
      // A carry out of the hidden bit means the mantissa rolled over to 1.000
      if (sum[MAN_W+1]) begin
         man_o  = sum[MAN_W:1];
         expAdj = exp_i + ONE_X;
      end else begin
         man_o  = sum[MAN_W-1:0];
         expAdj = exp_i;
      end
      exp_o      = expAdj[EXP_W-1:0];
      overflow_o = (expAdj >= ONES_X);
      inexact_o  = g_i | r_i | s_i;
   end

endmodule

// File: rtl/fp_addsub_param.sv
// Multi-cycle floating-point add/subtract with valid/ready handshake and RNE rounding.
module fp_addsub_param
   import fp_pkg::*;
#(
   parameter int EXP_W = 6,
   parameter int MAN_W = 25,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clock_100kHz,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op_sub,
   input  logic [W-1:0] op_A_in,
   input  logic [W-1:0] op_B_in,
   output logic [W-1:0] data_out,
   output logic [3:0]   status_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [2:0]   qual_lugar
);

   localparam int XW = EXP_W + 2;
   localparam int M  = MAN_W + 4;
   localparam logic signed [XW-1:0] ONE_X     = XW'(1);
   localparam logic signed [XW-1:0] ALIGN_MAX = XW'(MAN_W + 2);

   state_t               state_q;
   logic [W-1:0]         opA_q, opB_q, data_q;
   logic [3:0]           status_q;
   logic [M-1:0]         bigM_q, smallM_q;
   logic                 sticky_q, sign_q;
   logic signed [XW-1:0] exp_q, d_q;

   logic                 aSign, bSign, aZero, bZero, aInf, bInf, swap;
   logic [EXP_W-1:0]     aExp, bExp;
   logic [MAN_W-1:0]     aMan, bMan;
   logic [M-1:0]         aExt, bExt;
   logic signed [XW-1:0] aExpX, bExpX, dUnpack;

   assign {aSign, aExp, aMan} = opA_q;
   assign {bSign, bExp, bMan} = opB_q;
   assign aZero = (aExp == '0);
   assign bZero = (bExp == '0);
   assign aInf  = &aExp;
   assign bInf  = &bExp;
   // Extended mantissa layout: {carry, hidden, stored mantissa, guard, round}
   assign aExt  = aZero ? '0 : {1'b0, 1'b1, aMan, 2'b00};
   assign bExt  = bZero ? '0 : {1'b0, 1'b1, bMan, 2'b00};
   assign aExpX = $signed({2'b00, aExp});
   assign bExpX = $signed({2'b00, bExp});
   assign swap    = ({bExp, bExt} > {aExp, aExt});
   assign dUnpack = swap ? (bExpX - aExpX) : (aExpX - bExpX);

   logic         effSub, addS;
   logic [M:0]   diffExt;
   logic [M-1:0] addM;

   assign effSub  = aSign ^ bSign;
   // Sticky rides below the round bit so a subtract borrows from the discarded tail
   assign diffExt = {bigM_q, 1'b0} - {smallM_q, sticky_q};
   assign addM    = effSub ? diffExt[M:1] : (bigM_q + smallM_q);
   assign addS    = effSub ? diffExt[0] : sticky_q;

   logic [MAN_W-1:0] rMan;
   logic [EXP_W-1:0] rExp;
   logic             rInexact, rOverflow;
   logic [3:0]       roundStatus_d;

   fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
      .mant_i     (bigM_q[M-2:2]),
      .g_i        (bigM_q[1]),
      .r_i        (bigM_q[0]),
      .s_i        (sticky_q),
      .exp_i      (exp_q),
      .man_o      (rMan),
      .exp_o      (rExp),
      .inexact_o  (rInexact),
      .overflow_o (rOverflow)
   );

   always_comb begin
      roundStatus_d = '0;
      if (rOverflow)     roundStatus_d = STAT_OVERFLOW | STAT_INEXACT;
      else if (rInexact) roundStatus_d = STAT_INEXACT;
      else               roundStatus_d = STAT_EXACT;
   end

   always_ff @(posedge clock_100kHz or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         opA_q    <= '0;
         opB_q    <= '0;
         data_q   <= '0;
         status_q <= '0;
         bigM_q   <= '0;
         smallM_q <= '0;
         sticky_q <= 1'b0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         d_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               opA_q   <= op_A_in;
               opB_q   <= {op_B_in[W-1] ^ op_sub, op_B_in[W-2:0]};
               state_q <= S_UNPACK;
            end
            S_UNPACK: if (aInf || bInf) begin
               data_q   <= {(aInf ? aSign : bSign), {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               status_q <= STAT_OVERFLOW;
               state_q  <= S_DONE;
            end else begin
               bigM_q   <= swap ? bExt : aExt;
               smallM_q <= swap ? aExt : bExt;
               exp_q    <= swap ? bExpX : aExpX;
               sign_q   <= swap ? bSign : aSign;
               d_q      <= dUnpack;
               sticky_q <= 1'b0;
               state_q  <= (dUnpack == '0) ? S_ADD : S_ALIGN;
            end
            S_ALIGN: if (d_q > ALIGN_MAX) begin
               smallM_q <= '0;
               sticky_q <= sticky_q | (smallM_q != '0);
               d_q      <= '0;
               state_q  <= S_ADD;
            end else begin
               smallM_q <= smallM_q >> 1;
               sticky_q <= sticky_q | smallM_q[0];
               d_q      <= d_q - ONE_X;
               if (d_q == ONE_X) state_q <= S_ADD;
            end
            S_ADD: if (addM == '0 && !addS) begin
               data_q   <= '0;
               status_q <= STAT_EXACT;
               state_q  <= S_DONE;
            end else begin
               bigM_q   <= addM;
               sticky_q <= addS;
               state_q  <= S_NORM;
            end
            S_NORM: if (bigM_q[M-1]) begin
               bigM_q   <= bigM_q >> 1;
               sticky_q <= sticky_q | bigM_q[0];
               exp_q    <= exp_q + ONE_X;
               state_q  <= S_ROUND;
            end else if (bigM_q[M-2]) begin
               state_q <= S_ROUND;
            end else begin
               bigM_q <= {bigM_q[M-2:0], sticky_q};
               exp_q  <= exp_q - ONE_X;
               if (exp_q <= ONE_X) begin
                  data_q   <= {sign_q, {(W - 1){1'b0}}};
                  status_q <= STAT_UNDERFLOW | STAT_INEXACT;
                  state_q  <= S_DONE;
               end
            end
            S_ROUND: begin
               data_q   <= rOverflow ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                     : {sign_q, rExp, rMan};
               status_q <= roundStatus_d;
               state_q  <= S_DONE;
            end
            S_DONE: if (out_ready) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign qual_lugar = state_q;
   assign data_out   = data_q;
   assign status_out = status_q;

endmodule

// File: tb/tb_fp_addsub_param.sv
// Scoreboard bench for fp_addsub_param at default widths (1/6/25).
`timescale 1ns/1ps
module tb_fp_addsub_param;

   logic        clock_100kHz = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        op_sub = 1'b0;
   logic [31:0] op_A_in = '0;
   logic [31:0] op_B_in = '0;
   logic [31:0] data_out;
   logic [3:0]  status_out;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [2:0]  qual_lugar;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  status;
      string       tag;
   } expect_t;

   expect_t    sb[$];
   logic [2:0] trace[$];
   bit         traceOn = 1'b0;
   int         checkCount = 0;
   int         failCount = 0;

   always #5000 clock_100kHz = ~clock_100kHz;

   fp_addsub_param dut (
      .clock_100kHz (clock_100kHz),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .op_sub       (op_sub),
      .op_A_in      (op_A_in),
      .op_B_in      (op_B_in),
      .data_out     (data_out),
      .status_out   (status_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .qual_lugar   (qual_lugar)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Results are compared on the falling edge before the rising edge that consumes them
   always @(negedge clock_100kHz) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_result", 32'd1, 32'd0);
         end else begin
            expect_t e;
            e = sb.pop_front();
            checkOutput({e.tag, "_data"}, data_out, e.data);
            checkOutput({e.tag, "_status"}, {28'd0, status_out}, {28'd0, e.status});
         end
      end
   end

   always @(negedge clock_100kHz) begin
      if (traceOn && (trace.size() == 0 || trace[$] != qual_lugar))
         trace.push_back(qual_lugar);
   end

   task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input bit track,
                                input logic [31:0] expData, input logic [3:0] expStatus);
      int waitCycles = 0;
      expect_t e;
      @(negedge clock_100kHz);
      while (!in_ready && waitCycles < 200) begin
         @(negedge clock_100kHz);
         waitCycles++;
      end
      if (!in_ready) begin
         checkOutput({tag, "_in_ready_timeout"}, 32'd0, 32'd1);
         return;
      end
      op_A_in  = a;
      op_B_in  = b;
      op_sub   = sub;
      in_valid = 1'b1;
      if (track) begin
         e.data   = expData;
         e.status = expStatus;
         e.tag    = tag;
         sb.push_back(e);
      end
      @(negedge clock_100kHz);
      in_valid = 1'b0;
   endtask

   task automatic waitDrain(input string tag);
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 300) begin
         @(negedge clock_100kHz);
         n++;
      end
      checkOutput({tag, "_drain"}, {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
   endtask

   function automatic bit traceOk();
      int i = 0;
      int mid = 0;
      logic [2:0] prev = 3'd3;
      while (i < trace.size() && trace[i] == 3'd0) i++;
      for (int s = 1; s <= 3; s++) begin
         if (i >= trace.size() || trace[i] != 3'(s)) return 1'b0;
         i++;
      end
      while (i < trace.size() && (trace[i] == 3'd4 || trace[i] == 3'd5)) begin
         if (trace[i] <= prev) return 1'b0;
         prev = trace[i];
         i++;
         mid++;
      end
      if (mid == 0) return 1'b0;
      return (i < trace.size() && trace[i] == 3'd6);
   endfunction

   initial begin
      #200000000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      repeat (2) @(negedge clock_100kHz);
      checkOutput("rst_data", data_out, 32'h0);
      checkOutput("rst_status", {28'd0, status_out}, 32'h0);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rst_state", {29'd0, qual_lugar}, 32'd0);
      reset = 1'b0;

      traceOn = 1'b1;
      applyStimulus("t1_add", 32'h3E000000, 32'h40000000, 1'b0, 1'b1, 32'h41000000, 4'b0001);
      waitDrain("t1");
      traceOn = 1'b0;
      checkOutput("t1_state_seq", {31'd0, traceOk()}, 32'd1);

      applyStimulus("t2_negadd", 32'hBF000000, 32'hC0800000, 1'b0, 1'b1, 32'hC2000000, 4'b0001);
      waitDrain("t2");
      applyStimulus("t3_cancel", 32'h40800000, 32'hC0800000, 1'b0, 1'b1, 32'h00000000, 4'b0001);
      applyStimulus("t3_sub", 32'h3E000000, 32'h40000000, 1'b1, 1'b1, 32'hBE000000, 4'b0001);
      waitDrain("t3");
      applyStimulus("t4_tie_even", 32'h3E000000, 32'h0A000000, 1'b0, 1'b1, 32'h3E000000, 4'b1000);
      applyStimulus("x_round_up", 32'h3E000000, 32'h0B000000, 1'b0, 1'b1, 32'h3E000001, 4'b1000);
      applyStimulus("x_sticky_collapse", 32'h3E000000, 32'h02000000, 1'b0, 1'b1, 32'h3E000000, 4'b1000);
      applyStimulus("x_zero_plus", 32'h00000000, 32'h3E000000, 1'b0, 1'b1, 32'h3E000000, 4'b0001);
      applyStimulus("x_inf_a", 32'h7E000000, 32'h3E000000, 1'b0, 1'b1, 32'h7E000000, 4'b0010);
      applyStimulus("x_inf_b_sub", 32'h3E000000, 32'h7E000000, 1'b1, 1'b1, 32'hFE000000, 4'b0010);
      waitDrain("x");

      out_ready = 1'b0;
      applyStimulus("t5_overflow", 32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 1'b1, 32'h7E000000, 4'b1010);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clock_100kHz);
         n++;
      end
      checkOutput("t5_out_valid", {31'd0, out_valid}, 32'd1);
      op_A_in  = 32'h3E000000;
      op_B_in  = 32'h40000000;
      op_sub   = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock_100kHz);
         checkOutput("t5_hold_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("t5_hold_data", data_out, 32'h7E000000);
         checkOutput("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      @(posedge clock_100kHz);
      #1 out_ready = 1'b1;
      waitDrain("t5");
      repeat (4) @(negedge clock_100kHz);
      checkOutput("t5_ignored_in_valid", {29'd0, qual_lugar}, 32'd0);

      applyStimulus("t6_abort", 32'h3E000000, 32'h16000000, 1'b0, 1'b0, 32'h0, 4'b0);
      n = 0;
      while (qual_lugar != 3'd2 && n < 20) begin
         @(negedge clock_100kHz);
         n++;
      end
      checkOutput("t6_in_align", {29'd0, qual_lugar}, 32'd2);
      repeat (3) @(negedge clock_100kHz);
      #1000 reset = 1'b1;
      #1;
      checkOutput("t6_rst_state", {29'd0, qual_lugar}, 32'd0);
      checkOutput("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("t6_rst_data", data_out, 32'h0);
      checkOutput("t6_rst_status", {28'd0, status_out}, 32'h0);
      #2999 reset = 1'b0;
      repeat (5) @(negedge clock_100kHz);
      checkOutput("t6_idle_after", {29'd0, qual_lugar}, 32'd0);
      applyStimulus("t6_fresh", 32'h3E000000, 32'h40000000, 1'b0, 1'b1, 32'h41000000, 4'b0001);
      waitDrain("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
